// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode instruction queue.
// Buffers one fetched instruction per entry (PC, instruction bits, branch
// prediction, fetch exception) and presents the oldest entry to the decoder
// under a valid/ready handshake. Once an exception entry is accepted, fetch is
// refused until that entry has been consumed, so nothing fetched after a fault
// can reach decode.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RUN       | normal operation, fetch accepted whenever the queue has room
// ST_XCPT_HOLD | an exception entry is queued; fetch is refused until it pops
module fetch_instr_queue #(
    parameter int unsigned VADDR_WIDTH      = 32,
    parameter int unsigned MAX_ILEN         = 32,
    parameter int unsigned XCPT_CAUSE_WIDTH = 32,
    parameter int unsigned DEPTH            = 4,
    localparam int unsigned PTR_W           = $clog2(DEPTH),
    localparam int unsigned CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,

    input  logic                        fe_valid_i,
    output logic                        fe_ready_o,
    input  logic [VADDR_WIDTH-1:0]      fe_pc_i,
    input  logic [MAX_ILEN-1:0]         fe_instr_i,
    input  logic                        fe_bp_is_branch_i,
    input  logic                        fe_bp_decision_i,
    input  logic [VADDR_WIDTH-1:0]      fe_bp_pred_addr_i,
    input  logic                        fe_xcpt_valid_i,
    input  logic [XCPT_CAUSE_WIDTH-1:0] fe_xcpt_cause_i,

    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [VADDR_WIDTH-1:0]      instr_pc_o,
    output logic [MAX_ILEN-1:0]         instr_content_o,
    output logic                        bp_is_branch_o,
    output logic                        bp_decision_o,
    output logic [VADDR_WIDTH-1:0]      bp_pred_addr_o,
    output logic                        xcpt_valid_o,
    output logic [VADDR_WIDTH-1:0]      xcpt_origin_o,
    output logic [XCPT_CAUSE_WIDTH-1:0] xcpt_cause_o,

    output logic [CNT_W-1:0]            count_o
);

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_XCPT_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               xcpt_in_q, xcpt_in_d;

    // Entry storage; contents are only meaningful below count_q, so no reset.
    logic [VADDR_WIDTH-1:0]      pc_mem_q        [DEPTH];
    logic [MAX_ILEN-1:0]         instr_mem_q     [DEPTH];
    logic                        is_branch_mem_q [DEPTH];
    logic                        decision_mem_q  [DEPTH];
    logic [VADDR_WIDTH-1:0]      pred_addr_mem_q [DEPTH];
    logic                        xcpt_mem_q      [DEPTH];
    logic [XCPT_CAUSE_WIDTH-1:0] cause_mem_q     [DEPTH];

    logic head_valid;
    logic head_xcpt;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake qualification; fe_ready_o is built from registered state only.
    always_comb begin
        head_valid = (count_q != '0);
        head_xcpt  = xcpt_mem_q[rd_ptr_q];
        fe_ready_o = (count_q != CNT_W'(DEPTH)) && (state_q == ST_RUN);
        push       = fe_valid_i && fe_ready_o && !flush_i;
        pop        = head_valid && instr_ready_i && !flush_i;
    end

    // Pointer, occupancy and exception-tracking next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        xcpt_in_d = xcpt_in_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Only one exception entry can be queued at a time: pushes stop behind it.
        if (pop && head_xcpt) begin
            xcpt_in_d = 1'b0;
        end
        if (push && fe_xcpt_valid_i) begin
            xcpt_in_d = 1'b1;
        end

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            xcpt_in_d = 1'b0;
        end
    end

    // FSM next-state: hold fetch from an accepted fault until that entry leaves.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (push && fe_xcpt_valid_i) begin
                    state_d = ST_XCPT_HOLD;
                end
            end
            ST_XCPT_HOLD: begin
                if (xcpt_in_q && pop && head_xcpt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (flush_i) begin
            state_d = ST_RUN;
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            xcpt_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            xcpt_in_q <= xcpt_in_d;
        end
    end

    // Entry write on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]        <= fe_pc_i;
            instr_mem_q[wr_ptr_q]     <= fe_instr_i;
            is_branch_mem_q[wr_ptr_q] <= fe_bp_is_branch_i;
            decision_mem_q[wr_ptr_q]  <= fe_bp_decision_i;
            pred_addr_mem_q[wr_ptr_q] <= fe_bp_pred_addr_i;
            xcpt_mem_q[wr_ptr_q]      <= fe_xcpt_valid_i;
            cause_mem_q[wr_ptr_q]     <= fe_xcpt_cause_i;
        end
    end

    // Head presentation; payload is zeroed whenever there is no valid head.
    always_comb begin
        instr_valid_o   = head_valid;
        instr_pc_o      = '0;
        instr_content_o = '0;
        bp_is_branch_o  = 1'b0;
        bp_decision_o   = 1'b0;
        bp_pred_addr_o  = '0;
        xcpt_valid_o    = 1'b0;
        xcpt_origin_o   = '0;
        xcpt_cause_o    = '0;
        count_o         = count_q;
        if (head_valid) begin
            instr_pc_o      = pc_mem_q[rd_ptr_q];
            instr_content_o = instr_mem_q[rd_ptr_q];
            bp_is_branch_o  = is_branch_mem_q[rd_ptr_q];
            bp_decision_o   = decision_mem_q[rd_ptr_q];
            bp_pred_addr_o  = pred_addr_mem_q[rd_ptr_q];
            xcpt_valid_o    = head_xcpt;
            if (head_xcpt) begin
                xcpt_origin_o = pc_mem_q[rd_ptr_q];
                xcpt_cause_o  = cause_mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Testbench for fetch_instr_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_instr_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br;
        logic        dec;
        logic [31:0] pa;
        logic        xv;
        logic [31:0] xc;
    } entry_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        fe_valid_i;
    logic        fe_ready_o;
    logic [31:0] fe_pc_i;
    logic [31:0] fe_instr_i;
    logic        fe_bp_is_branch_i;
    logic        fe_bp_decision_i;
    logic [31:0] fe_bp_pred_addr_i;
    logic        fe_xcpt_valid_i;
    logic [31:0] fe_xcpt_cause_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_content_o;
    logic        bp_is_branch_o;
    logic        bp_decision_o;
    logic [31:0] bp_pred_addr_o;
    logic        xcpt_valid_o;
    logic [31:0] xcpt_origin_o;
    logic [31:0] xcpt_cause_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;

    entry_t mq[$];

    fetch_instr_queue #(
        .VADDR_WIDTH(32), .MAX_ILEN(32), .XCPT_CAUSE_WIDTH(32), .DEPTH(DEPTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .fe_valid_i        (fe_valid_i),
        .fe_ready_o        (fe_ready_o),
        .fe_pc_i           (fe_pc_i),
        .fe_instr_i        (fe_instr_i),
        .fe_bp_is_branch_i (fe_bp_is_branch_i),
        .fe_bp_decision_i  (fe_bp_decision_i),
        .fe_bp_pred_addr_i (fe_bp_pred_addr_i),
        .fe_xcpt_valid_i   (fe_xcpt_valid_i),
        .fe_xcpt_cause_i   (fe_xcpt_cause_i),
        .instr_valid_o     (instr_valid_o),
        .instr_ready_i     (instr_ready_i),
        .instr_pc_o        (instr_pc_o),
        .instr_content_o   (instr_content_o),
        .bp_is_branch_o    (bp_is_branch_o),
        .bp_decision_o     (bp_decision_o),
        .bp_pred_addr_o    (bp_pred_addr_o),
        .xcpt_valid_o      (xcpt_valid_o),
        .xcpt_origin_o     (xcpt_origin_o),
        .xcpt_cause_o      (xcpt_cause_o),
        .count_o           (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: fetch is accepted when there is room and no queued entry is faulting.
    function automatic logic model_ready();
        if (mq.size() == DEPTH) return 1'b0;
        foreach (mq[i]) if (mq[i].xv) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [255:0] obs_pl;
        logic [255:0] exp_pl;
        entry_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        obs_pl = {instr_pc_o, instr_content_o, bp_is_branch_o, bp_decision_o,
                  bp_pred_addr_o, xcpt_valid_o, xcpt_origin_o, xcpt_cause_o};
        exp_pl = {h.pc, h.instr, h.br, h.dec, h.pa, h.xv,
                  (h.xv ? h.pc : 32'h0), (h.xv ? h.xc : 32'h0)};
        check({tag, ".valid"}, 256'(instr_valid_o), 256'(mq.size() != 0));
        check({tag, ".ready"}, 256'(fe_ready_o), 256'(model_ready()));
        check({tag, ".count"}, 256'(count_o), 256'(mq.size()));
        check({tag, ".payload"}, obs_pl, exp_pl);
    endtask

    function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                  input logic br, input logic dec, input logic [31:0] pa,
                                  input logic xv, input logic [31:0] xc);
        entry_t e;
        e.pc = pc; e.instr = instr; e.br = br; e.dec = dec;
        e.pa = pa; e.xv = xv; e.xc = xc;
        return e;
    endfunction

    function automatic entry_t rnd_entry(input logic xv);
        return mk($urandom, $urandom, 1'($urandom), 1'($urandom), $urandom, xv, $urandom);
    endfunction

    // One cycle, entered and left at a falling edge: check, drive, clock, update model.
    task automatic step(input string tag, input logic v, input logic r, input logic f,
                        input entry_t e);
        logic do_push, do_pop;
        check_outputs(tag);
        fe_valid_i        = v;
        instr_ready_i     = r;
        flush_i           = f;
        fe_pc_i           = e.pc;
        fe_instr_i        = e.instr;
        fe_bp_is_branch_i = e.br;
        fe_bp_decision_i  = e.dec;
        fe_bp_pred_addr_i = e.pa;
        fe_xcpt_valid_i   = e.xv;
        fe_xcpt_cause_i   = e.xc;
        do_push = v && model_ready() && !f;
        do_pop  = (mq.size() != 0) && r && !f;
        @(posedge clk_i);
        if (f) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        @(negedge clk_i);
    endtask

    initial begin
        entry_t e;
        rst_ni = 1'b0;
        flush_i = 1'b0;
        instr_ready_i = 1'b0;
        // Plan 1: reset with fetch valid held high.
        e = mk(32'h1000, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        fe_valid_i = 1'b1;
        fe_pc_i = e.pc; fe_instr_i = e.instr; fe_bp_is_branch_i = 1'b0;
        fe_bp_decision_i = 1'b0; fe_bp_pred_addr_i = '0;
        fe_xcpt_valid_i = 1'b0; fe_xcpt_cause_i = '0;
        repeat (3) begin
            @(negedge clk_i);
            check_outputs("reset");
        end
        rst_ni = 1'b1;
        step("rel", 1'b1, 1'b0, 1'b0, e);
        check("first_push_pc", 256'(instr_pc_o), 256'(32'h1000));
        step("first", 1'b0, 1'b1, 1'b0, e);

        // Plan 2: fill, hold the fifth push, then drain in order.
        for (int k = 0; k < 4; k++)
            step("fill", 1'b1, 1'b0, 1'b0, mk(32'(4 * k), $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        check("full_count", 256'(count_o), 256'(3'd4));
        check("full_ready", 256'(fe_ready_o), 256'(1'b0));
        step("fifth", 1'b1, 1'b0, 1'b0, mk(32'h10, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        step("fullpop", 1'b1, 1'b1, 1'b0, mk(32'h14, 32'h2, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        for (int k = 0; k < 5; k++)
            step("drain", 1'b0, 1'b1, 1'b0, '0);

        // Plan 3: streaming, count stays at one and pointers wrap.
        for (int k = 0; k < 10; k++)
            step("stream", 1'b1, 1'b1, 1'b0, mk(32'h100 + 32'(4 * k), $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        check("stream_count", 256'(count_o), 256'(3'd1));
        step("stream_end", 1'b0, 1'b1, 1'b0, '0);

        // Plan 4: flush with concurrent push and pop.
        for (int k = 0; k < 3; k++) step("pre_flush", 1'b1, 1'b0, 1'b0, rnd_entry(1'b0));
        step("flush", 1'b1, 1'b1, 1'b1, rnd_entry(1'b0));
        check("post_flush_count", 256'(count_o), 256'(3'd0));
        check("post_flush_ready", 256'(fe_ready_o), 256'(1'b1));

        // Plan 5: exception entry blocks fetch until it pops.
        step("xcpt_push", 1'b1, 1'b0, 1'b0, mk(32'h200, 32'h33, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1));
        check("xcpt_ready", 256'(fe_ready_o), 256'(1'b0));
        check("xcpt_head", 256'({xcpt_valid_o, xcpt_origin_o, xcpt_cause_o}),
              256'({1'b1, 32'h200, 32'h1}));
        step("xcpt_blocked", 1'b1, 1'b0, 1'b0, rnd_entry(1'b0));
        step("xcpt_pop", 1'b1, 1'b1, 1'b0, rnd_entry(1'b0));
        check("xcpt_release", 256'(fe_ready_o), 256'(1'b1));

        // Plan 6: branch prediction fields forwarded.
        step("bp_push", 1'b1, 1'b0, 1'b0, mk(32'h300, 32'h63, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0));
        check("bp_head", 256'({bp_is_branch_o, bp_decision_o, bp_pred_addr_o, xcpt_valid_o, xcpt_cause_o}),
              256'({1'b1, 1'b1, 32'h400, 1'b0, 32'h0}));
        step("bp_pop", 1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset in the middle of traffic.
        for (int k = 0; k < 3; k++) step("pre_rst", 1'b1, 1'b0, 1'b0, rnd_entry(1'b0));
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_count", 256'(count_o), 256'(3'd0));
        check("async_rst_valid", 256'(instr_valid_o), 256'(1'b0));
        mq.delete();
        fe_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), rnd_entry(1'($urandom_range(0, 9) == 0)));
        end
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
Decoupling FIFO between the fetch unit and simple_instr_deco, buffering one fetched instruction per entry.
Each entry carries the PC, instruction bits, branch-prediction info and any fetch exception.
The head entry is presented to the decoder's instr_*/bp_*/xcpt_* inputs under a valid/ready handshake.
Accepting fetch is gated after an exception entry, so nothing past a faulting fetch reaches decode.

Parameters:
VADDR_WIDTH, 32, virtual address width.
MAX_ILEN, 32, instruction width.
XCPT_CAUSE_WIDTH, 32, exception cause width.
DEPTH, 4, number of entries; power of two, at least 2.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
flush_i  input  1  discard all entries (redirect/mispredict).
fe_valid_i  input  1  fetch presents an entry.
fe_ready_o  output  1  queue accepts an entry this cycle.
fe_pc_i  input  VADDR_WIDTH  fetched PC.
fe_instr_i  input  MAX_ILEN  fetched instruction.
fe_bp_is_branch_i  input  1  predictor flags the instruction as a branch.
fe_bp_decision_i  input  1  predicted taken.
fe_bp_pred_addr_i  input  VADDR_WIDTH  predicted target.
fe_xcpt_valid_i  input  1  fetch exception on this entry.
fe_xcpt_cause_i  input  XCPT_CAUSE_WIDTH  exception cause.
instr_valid_o  output  1  head entry valid (to decoder instr_valid_i).
instr_ready_i  input  1  decoder consumes the head this cycle.
instr_pc_o  output  VADDR_WIDTH  head PC.
instr_content_o  output  MAX_ILEN  head instruction.
bp_is_branch_o, bp_decision_o  output  1 each  head prediction flags.
bp_pred_addr_o  output  VADDR_WIDTH  head predicted target.
xcpt_valid_o  output  1  head carries an exception.
xcpt_origin_o  output  VADDR_WIDTH  equals the head PC when xcpt_valid_o=1, else 0.
xcpt_cause_o  output  XCPT_CAUSE_WIDTH  head cause when xcpt_valid_o=1, else 0.
count_o  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - wr_ptr, rd_ptr and count are 0; FSM state is RUN.
  - Outputs: instr_valid_o=0, fe_ready_o=1, count_o=0, all payload outputs 0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Push: occurs when fe_valid_i & fe_ready_o & !flush_i.
  - The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when instr_valid_o & instr_ready_i & !flush_i.
  - rd_ptr increments modulo DEPTH.
- count update: count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1. There is no same-cycle bypass.
- instr_valid_o = (count != 0).
  - Payload outputs are the head-entry fields when valid; otherwise they are forced to 0.
- Full queue:
  - fe_ready_o = (count != DEPTH) and state == RUN.
  - fe_ready_o depends only on registered state, with no combinational path from instr_ready_i. A full queue with a concurrent pop therefore still refuses the push that cycle.
- Empty queue: instr_ready_i is ignored and no pop occurs.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- FSM:
  - RUN: a push with fe_xcpt_valid_i=1 moves to XCPT_HOLD.
  - XCPT_HOLD: fe_ready_o=0.
    - Return to RUN when the exception entry pops. Track this with a registered flag xcpt_in_q, set on the push and cleared on the pop of any entry with the xcpt bit set.
    - Return to RUN on flush_i.
- Flush: on flush_i=1 at the rising edge:
  - count, wr_ptr and rd_ptr become 0 and the state becomes RUN.
  - Any push or pop presented in that cycle is dropped.
  - In the following cycle, instr_valid_o=0 and fe_ready_o=1.
- Branch-prediction and exception fields are stored and forwarded unmodified. The queue does not check them for consistency.

Test Plan:
1. Reset with fe_valid_i=1 held, then release -> cycle after release: fe_ready_o=1, instr_valid_o=0, count_o=0; first push of pc=0x1000, instr=0x00000013 appears next cycle with instr_valid_o=1.
2. Push PCs 0x0,0x4,0x8,0xC with instr_ready_i=0 -> count_o=4, fe_ready_o=0; fifth push is held; raise instr_ready_i -> PCs pop in order 0x0..0xC.
3. Streaming with fe_valid_i=instr_ready_i=1 for 10 cycles (PCs 0x100+4k) -> count_o stays 1, outputs ordered, pointers wrap twice with no loss or duplication.
4. Queue holds 3 entries; assert flush_i together with fe_valid_i and instr_ready_i -> next cycle count_o=0, instr_valid_o=0, fe_ready_o=1, and no entry was popped to the decoder.
5. Push pc=0x200 with fe_xcpt_valid_i=1, cause=0x1 -> fe_ready_o=0 next cycle; the head shows xcpt_valid_o=1, xcpt_origin_o=0x200, xcpt_cause_o=0x1; after it pops, fe_ready_o=1.
6. Push pc=0x300 with bp_is_branch=1, decision=1, pred_addr=0x400 -> head outputs bp_is_branch_o=1, bp_decision_o=1, bp_pred_addr_o=0x400, xcpt_valid_o=0, xcpt_cause_o=0.
